// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 MULT/MULTU/DIV/DIVU engine with architectural HI/LO registers.
// Build option MULDIV_EARLY_TERM_EN: a multiply finishes early once the remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mdstart,
  input  logic             signedop,
  input  logic             muldivb,
  input  logic             hilosrc,
  input  logic [1:0]       hilodisable,
  input  logic             hiloread,
  input  logic             hilosel,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic [WIDTH-1:0] hiloout,
  output logic             mdbusy,
  output logic             mdstall
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_step, prod;
  logic [WIDTH-1:0]   opd, hi, lo, hi_res, lo_res;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic               is_mul, neg_q, neg_r, div_zero;
  logic               early, start, mt_wr;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // acc holds {partial product, unshifted multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & opd};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    if (is_mul)
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    else if (div_shift >= {1'b0, opd})
      acc_step = {div_shift[WIDTH-1:0] - opd, acc[WIDTH-2:0], 1'b1};
    else
      acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

`ifdef MULDIV_EARLY_TERM_EN
  logic [WIDTH-1:0] mplier_left;
  // the low cnt bits of acc are the multiplier bits not yet consumed
  always_comb begin
    mplier_left = acc[WIDTH-1:0] << (WIDTH - int'(cnt));
    early       = is_mul && (mplier_left == '0);
  end
`else
  assign early = 1'b0;
`endif

  assign start = (state == IDLE) && mdstart;
  assign mt_wr = (state == IDLE) && !mdstart && hilosrc;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mdstart) state_nxt = RUN;
      RUN:     if (early || cnt == CW'(1)) state_nxt = FIXUP;
      FIXUP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset)              cnt <= '0;
    else if (start)         cnt <= CW'(WIDTH);
    else if (state == RUN)  cnt <= cnt - CW'(1);
  end

  // Operand capture and per-cycle iteration
  always_ff @(posedge clk) begin
    if (start) begin
      is_mul   <= muldivb;
      neg_q    <= signedop & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
      neg_r    <= signedop & srca[WIDTH-1];
      div_zero <= ~muldivb & (srcb == '0);
      opd      <= muldivb ? magnitude(srca, signedop) : magnitude(srcb, signedop);
      acc      <= {{WIDTH{1'b0}}, (muldivb ? magnitude(srcb, signedop) : magnitude(srca, signedop))};
    end else if (state == RUN) begin
      if (early) acc <= acc >> cnt;
      else       acc <= acc_step;
    end
  end

  // Sign fix-up; a zero divisor leaves the dividend magnitude as remainder, so HI recovers srca
  always_comb begin
    prod = cneg_2w(acc, neg_q);
    if (is_mul) begin
      hi_res = prod[2*WIDTH-1:WIDTH];
      lo_res = prod[WIDTH-1:0];
    end else begin
      hi_res = cneg_w(acc[2*WIDTH-1:WIDTH], neg_r);
      lo_res = div_zero ? {WIDTH{1'b1}} : cneg_w(acc[WIDTH-1:0], neg_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIXUP) begin
      hi <= hi_res;
      lo <= lo_res;
    end else if (mt_wr) begin
      if (!hilodisable[0]) hi <= srca;
      if (!hilodisable[1]) lo <= srca;
    end
  end

  assign mdbusy  = (state != IDLE);
  assign mdstall = mdbusy & (mdstart | hilosrc | hiloread);
  assign hiloout = hilosel ? lo : hi;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops against a behavioural HI/LO model.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mdstart = 1'b0, signedop = 1'b0, muldivb = 1'b0, hilosrc = 1'b0;
  logic [1:0]  hilodisable = 2'b00;
  logic        hiloread = 1'b0, hilosel = 1'b0;
  logic [31:0] srca = '0, srcb = '0;
  logic [31:0] hiloout;
  logic        mdbusy, mdstall;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .mdstart(mdstart), .signedop(signedop), .muldivb(muldivb),
    .hilosrc(hilosrc), .hilodisable(hilodisable), .hiloread(hiloread), .hilosel(hilosel),
    .srca(srca), .srcb(srcb), .hiloout(hiloout), .mdbusy(mdbusy), .mdstall(mdstall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // Behavioural model: architectural HI/LO plus cycles remaining until the pending result lands
  logic [31:0] mhi = '0, mlo = '0, phi = '0, plo = '0;
  int          mrem = 0;

  function automatic logic [63:0] ref_result(input logic mul, input logic sgn,
                                             input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    int     sa, sb;
    if (mul) begin
      if (sgn) begin
        x = $signed(a);
        y = $signed(b);
        return 64'(x * y);
      end
      return {32'b0, a} * {32'b0, b};
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sa = $signed(a);
      sb = $signed(b);
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction

  function automatic int ref_latency(input logic mul, input logic sgn, input logic [31:0] b);
`ifdef MULDIV_EARLY_TERM_EN
    logic [31:0] m;
    int          top;
    if (!mul) return 33;
    m   = (sgn && b[31]) ? -b : b;
    top = -1;
    for (int i = 0; i < 32; i++) if (m[i]) top = i;
    return (top + 3 > 33) ? 33 : top + 3;
`else
    return 33;
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mhi  <= '0;
      mlo  <= '0;
      mrem <= 0;
    end else if (mrem > 0) begin
      mrem <= mrem - 1;
      if (mrem == 1) begin
        mhi <= phi;
        mlo <= plo;
      end
    end else if (mdstart) begin
      {phi, plo} <= ref_result(muldivb, signedop, srca, srcb);
      mrem       <= ref_latency(muldivb, signedop, srcb);
    end else if (hilosrc) begin
      if (!hilodisable[0]) mhi <= srca;
      if (!hilodisable[1]) mlo <= srca;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("mdbusy", 32'(mdbusy), 32'(mrem != 0));
      chk("mdstall", 32'(mdstall), 32'((mrem != 0) && (mdstart || hilosrc || hiloread)));
      if (!((mrem != 0) && (mdstart || hilosrc || hiloread)))
        chk("hiloout", hiloout, hilosel ? mlo : mhi);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_until_accepted();
    int g;
    g = 0;
    while (mrem != 0 && g < 200) begin
      cycle();
      g++;
    end
    cycle();
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (mrem != 0 && g < 200) begin
      cycle();
      g++;
    end
    if (mrem != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: still busy after %0d cycles", g);
    end
  endtask

  task automatic read_check(input string name, input logic [31:0] ehi, input logic [31:0] elo);
    hilosel = 1'b0;
    #1;
    chk({name, "_hi"}, hiloout, ehi);
    chk({name, "_model_hi"}, mhi, ehi);
    hilosel = 1'b1;
    #1;
    chk({name, "_lo"}, hiloout, elo);
    chk({name, "_model_lo"}, mlo, elo);
  endtask

  task automatic mt_op(input logic [31:0] v, input logic [1:0] dis);
    srca = v;
    hilodisable = dis;
    hilosrc = 1'b1;
    hold_until_accepted();
    hilosrc = 1'b0;
    hilodisable = 2'b00;
  endtask

  task automatic run_op(input logic mul, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int follow);
    muldivb = mul;
    signedop = sgn;
    srca = a;
    srcb = b;
    mdstart = 1'b1;
    hold_until_accepted();
    mdstart = 1'b0;
    if (follow == 1) begin
      hiloread = 1'b1;
      hilosel = 1'($urandom_range(0, 1));
      hold_until_accepted();
      hiloread = 1'b0;
    end else if (follow == 2) begin
      mt_op($urandom, 2'($urandom_range(0, 3)));
    end
    wait_idle();
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] corners [5];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    case ($urandom_range(0, 3))
      0:       return corners[$urandom_range(0, 4)];
      1:       return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    int sel;
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int sel;
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    check_en = 1'b1;
    chk("reset_mdbusy", 32'(mdbusy), 32'd0);
    read_check("reset", 32'h0, 32'h0);
    mdstart = 1'b1;
    #1;
    chk("idle_start_nostall", 32'(mdstall), 32'd0);
    mdstart = 1'b0;

    run_op(1'b1, 1'b1, 32'hFFFF_FFFE, 32'h3, 0);
    read_check("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op(1'b1, 1'b0, 32'hFFFF_FFFE, 32'h3, 0);
    read_check("multu", 32'h2, 32'hFFFF_FFFA);
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'h2, 0);
    read_check("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(1'b0, 1'b0, 32'h7, 32'h2, 0);
    read_check("divu", 32'h1, 32'h3);
    run_op(1'b0, 1'b1, 32'h1234_5678, 32'h0, 0);
    read_check("div0", 32'h1234_5678, 32'hFFFF_FFFF);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    read_check("divovf", 32'h0, 32'h8000_0000);

    // MFLO arriving while a MULT is in flight
    muldivb = 1'b1; signedop = 1'b1; srca = 32'hFFFF_FFFE; srcb = 32'h3;
    mdstart = 1'b1;
    cycle();
    mdstart = 1'b0;
    repeat (4) cycle();
    hiloread = 1'b1;
    hilosel = 1'b1;
    #1;
    chk("mflo_stalled", 32'(mdstall), 32'd1);
    wait_idle();
    chk("mflo_released", 32'(mdstall), 32'd0);
    chk("mflo_value", hiloout, 32'hFFFF_FFFA);
    cycle();
    hiloread = 1'b0;

    mt_op(32'hAAAA_5555, 2'b10);
    read_check("mthi", 32'hAAAA_5555, 32'hFFFF_FFFA);

    // Reset in the middle of a run
    muldivb = 1'b1; signedop = 1'b0; srca = 32'hDEAD_BEEF; srcb = 32'h1357_9BDF;
    mdstart = 1'b1;
    cycle();
    mdstart = 1'b0;
    repeat (10) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("abort_mdbusy", 32'(mdbusy), 32'd0);
    read_check("abort", 32'h0, 32'h0);
    run_op(1'b1, 1'b0, 32'd3, 32'd4, 0);
    read_check("multu_3x4", 32'h0, 32'd12);

    // Busy-window length of a multiply with a tiny multiplier
    muldivb = 1'b1; signedop = 1'b0; srca = 32'h1234; srcb = 32'h1;
    mdstart = 1'b1;
    cycle();
    mdstart = 1'b0;
    n = 0;
    while (mdbusy && n < 100) begin
      n++;
      cycle();
    end
`ifdef MULDIV_EARLY_TERM_EN
    chk("early_busy_cycles", 32'(n), 32'd3);
`else
    chk("busy_cycles", 32'(n), 32'd33);
`endif
    read_check("multu_1234", 32'h0, 32'h1234);

    // mdstart and hilosrc together: the multiply wins
    muldivb = 1'b1; signedop = 1'b0; srca = 32'd5; srcb = 32'd6; hilodisable = 2'b00;
    mdstart = 1'b1;
    hilosrc = 1'b1;
    cycle();
    mdstart = 1'b0;
    hilosrc = 1'b0;
    wait_idle();
    read_check("start_wins", 32'h0, 32'd30);

    for (int k = 0; k < 80; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)
        run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_operand(), rand_operand(),
               $urandom_range(0, 2));
      else if (sel < 8)
        mt_op($urandom, 2'($urandom_range(0, 3)));
      else begin
        hiloread = 1'b1;
        hilosel = 1'($urandom_range(0, 1));
        cycle();
        hiloread = 1'b0;
      end
    end
    cycle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
